ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Main-memory-side responder for the `ram_if` protocol.
- Services one `ramREN`/`ramWEN` access at a time from the memory arbiter against an internal word-addressed backing store.
- Inserts a configurable number of wait cycles per access and reports progress on `ramstate`, which the arbiter decodes into its `iwait`/`dwait`/`swait`.
- Used as the simulation/FPGA main memory behind the arbiter.

Parameters:
- DW, 64, data width in bits of `ramstore` and `ramload`.
- AW, 32, byte-address width of `ramaddr`.
- DEPTH, 1024, number of DW-bit words in the backing store; must be a power of 2.
- LAT, 4, BUSY cycles per access; must be ≥1.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- nRST  input  1  asynchronous active-low reset.
- ramREN  input  1  read request; level-held by the initiator until ACCESS is seen.
- ramWEN  input  1  write request; level-held by the initiator until ACCESS is seen.
- ramaddr  input  AW  byte address; must be DW/8-aligned.
- ramstore  input  DW  write data.
- ramload  output  DW  read data; valid while `ramstate` == ACCESS for a read.
- ramstate  output  2  FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11; driven directly from the state register.

Behaviour:
- Reset:
  - state=FREE, `ramload`=0, latched addr/data/op=0, counter=0.
  - Backing-store contents are not reset.
- Word index: `ramaddr[3 +: log2(DEPTH)]` (byte offset bits [2:0] for DW=64).
- Request is legal when exactly one of REN/WEN is high, `ramaddr[2:0]`==0, and `ramaddr` < DEPTH*8.
- FREE:
  - no request → stay FREE.
  - illegal request → ERROR.
  - legal request → latch op, addr and `ramstore`; counter=LAT; go BUSY.
- BUSY:
  - Each cycle, compare live {REN, WEN, ramaddr, ramstore} against the latched copy.
  - Both REN and WEN low → abort to FREE, no memory change.
  - Mismatch with a legal request → relatch, counter=LAT, stay BUSY (restart).
  - Mismatch with an illegal request → ERROR.
  - Match → decrement counter; on the cycle the counter reaches 1, next state is ACCESS.
- Transition into ACCESS:
  - Read: `ramload` ← mem[idx] on that edge.
  - Write: mem[idx] ← latched data on that edge.
  - Net effect: a write is visible to any later access.
- ACCESS: lasts exactly 1 cycle, then FREE unconditionally. Request inputs are ignored during ACCESS.
- ERROR: lasts exactly 1 cycle, then FREE. No memory or `ramload` change.
- Timing for a legal request first seen in FREE at cycle t:
  - BUSY for cycles t+1 .. t+LAT.
  - ACCESS at cycle t+LAT+1.
  - FREE at cycle t+LAT+2.
  - Back-to-back accesses are therefore LAT+2 cycles apart.
- A request still held high in the FREE cycle after ACCESS is treated as a new access. The arbiter must drop REN/WEN on seeing ACCESS.
- `ramload` holds its last read value through non-read cycles.
- Asynchronous reset mid-access returns to FREE immediately. A write not yet in ACCESS is never committed.

Test Plan:
- Write then read, LAT=4: WEN, addr 0x10, data 0xDEADBEEF_CAFEF00D at cycle 0 → BUSY cycles 1-4, ACCESS cycle 5, FREE cycle 6. Then REN addr 0x10 → ACCESS with `ramload`=0xDEADBEEF_CAFEF00D.
- Restart: REN addr 0x8 held 2 BUSY cycles, then addr changes to 0x18 → counter reloads; ACCESS occurs LAT+1 cycles after the change; `ramload`=mem[3].
- Abort: WEN addr 0x20 data 0x1, REN/WEN dropped after 2 BUSY cycles → FREE next cycle. A subsequent read of 0x20 returns the prior content, not 0x1.
- Errors: REN=WEN=1 in FREE → ERROR 1 cycle, then FREE. Read at addr 0x4 (misaligned) → ERROR. Read at addr DEPTH*8 → ERROR. `ramload` unchanged in all three cases.
- Reset mid-write: nRST low during BUSY of a write of 0x55 to addr 0x0 → `ramstate`=FREE and `ramload`=0 immediately. A later read of 0x0 does not return 0x55 (bench pre-writes 0xAA and expects 0xAA).

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: main-memory responder for the ram_if protocol.
// One read or write is serviced at a time against a word-addressed backing
// store. Each access takes LAT BUSY cycles followed by a single ACCESS cycle.
// Progress is reported on ramstate for the arbiter to decode into wait signals.
module ram_responder #(
  parameter int DW    = 64,
  parameter int AW    = 32,
  parameter int DEPTH = 1024,
  parameter int LAT   = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          ramREN,
  input  logic          ramWEN,
  input  logic [AW-1:0] ramaddr,
  input  logic [DW-1:0] ramstore,
  output logic [DW-1:0] ramload,
  output logic [1:0]    ramstate
);

  localparam int OFFW = $clog2(DW / 8);
  localparam int IDXW = $clog2(DEPTH);
  localparam int CW   = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic            wen_q, wen_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   load_q;
  logic            memWr;
  logic            loadRd;

  logic [DW-1:0]   mem [DEPTH];

  logic            reqAny;
  logic            reqOne;
  logic            aligned;
  logic            inRange;
  logic            legal;
  logic [IDXW-1:0] liveIdx;
  logic [AW-1:0]   addrHigh;

  // A legal request only ever latches the word index and the write flag:
  // its offset and upper address bits are zero by definition, so an illegal
  // live address always differs from the latched copy and is caught by legal.
  assign reqAny   = ramREN | ramWEN;
  assign reqOne   = ramREN ^ ramWEN;
  assign aligned  = (ramaddr[OFFW-1:0] == '0);
  assign addrHigh = ramaddr >> (OFFW + IDXW);
  assign inRange  = (addrHigh == '0);
  assign legal    = reqOne & aligned & inRange;
  assign liveIdx  = ramaddr[OFFW +: IDXW];

  // Next-state logic: latch, restart, count down, commit or abort.
  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    memWr   = 1'b0;
    loadRd  = 1'b0;
    case (state_q)
      FREE: begin
        if (reqAny) begin
          if (legal) begin
            wen_d   = ramWEN;
            idx_d   = liveIdx;
            data_d  = ramstore;
            cnt_d   = CW'(LAT);
            state_d = BUSY;
          end else begin
            state_d = ERROR;
          end
        end
      end
      BUSY: begin
        if (!reqAny) begin
          state_d = FREE;
        end else if (!legal) begin
          state_d = ERROR;
        end else if ((ramWEN != wen_q) || (liveIdx != idx_q) || (ramstore != data_q)) begin
          wen_d  = ramWEN;
          idx_d  = liveIdx;
          data_d = ramstore;
          cnt_d  = CW'(LAT);
        end else if (cnt_q == CW'(1)) begin
          state_d = ACCESS;
          memWr   = wen_q;
          loadRd  = ~wen_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACCESS:  state_d = FREE;
      ERROR:   state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  // State, latched request and read-data register with asynchronous reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FREE;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      if (loadRd) begin
        load_q <= mem[idx_q];
      end
    end
  end

  // Backing store: contents survive reset, written only on entry to ACCESS.
  always_ff @(posedge CLK) begin
    if (memWr) begin
      mem[idx_q] <= data_q;
    end
  end

  assign ramload  = load_q;
  assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed-vector bench for ram_responder with LAT=4.
module tb_ram_responder;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BUSY   = 2'b01;
  localparam logic [1:0] S_ACCESS = 2'b10;
  localparam logic [1:0] S_ERROR  = 2'b11;

  logic          CLK;
  logic          nRST;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic [1:0]    ramstate;

  int            vectorCount;
  int            missCount;
  logic [DW-1:0] lastLoad;

  ram_responder #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .LAT(LAT)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .ramREN(ramREN),
    .ramWEN(ramWEN),
    .ramaddr(ramaddr),
    .ramstore(ramstore),
    .ramload(ramload),
    .ramstate(ramstate)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic dropReq();
    ramREN = 1'b0;
    ramWEN = 1'b0;
  endtask

  // Full legal access: FREE at t, BUSY t+1..t+LAT, ACCESS t+LAT+1, FREE after.
  task automatic applyStimulus(input string tag, input logic isWrite,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [DW-1:0] expLoad);
    ramREN   = ~isWrite;
    ramWEN   = isWrite;
    ramaddr  = addr;
    ramstore = data;
    checkOutput({tag, " free"}, DW'(ramstate), DW'(S_FREE));
    for (int i = 0; i < LAT; i++) begin
      tick();
      checkOutput({tag, " busy"}, DW'(ramstate), DW'(S_BUSY));
    end
    tick();
    checkOutput({tag, " access"}, DW'(ramstate), DW'(S_ACCESS));
    if (!isWrite) lastLoad = expLoad;
    checkOutput({tag, " load"}, ramload, lastLoad);
    dropReq();
    tick();
    checkOutput({tag, " back free"}, DW'(ramstate), DW'(S_FREE));
  endtask

  // Illegal request: one ERROR cycle, then FREE, ramload untouched.
  task automatic applyError(input string tag, input logic ren, input logic wen,
                            input logic [AW-1:0] addr);
    ramREN  = ren;
    ramWEN  = wen;
    ramaddr = addr;
    tick();
    checkOutput({tag, " error"}, DW'(ramstate), DW'(S_ERROR));
    dropReq();
    tick();
    checkOutput({tag, " free"}, DW'(ramstate), DW'(S_FREE));
    checkOutput({tag, " load"}, ramload, lastLoad);
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    lastLoad    = '0;
    nRST        = 1'b0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    // Reset state
    #12;
    checkOutput("reset state", DW'(ramstate), DW'(S_FREE));
    checkOutput("reset load", ramload, '0);
    tick();
    nRST = 1'b1;
    tick();

    // Write then read back
    applyStimulus("wr 0x10", 1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, '0);
    applyStimulus("rd 0x10", 1'b0, 32'h10, '0, 64'hDEADBEEF_CAFEF00D);

    // Preload words used later
    applyStimulus("wr 0x0", 1'b1, 32'h0, 64'hAA, '0);
    applyStimulus("wr 0x8", 1'b1, 32'h8, 64'h2222, '0);
    applyStimulus("wr 0x18", 1'b1, 32'h18, 64'h3333, '0);
    applyStimulus("wr 0x20", 1'b1, 32'h20, 64'h1234, '0);
    applyStimulus("wr top", 1'b1, 32'h1FF8, 64'h7777_0000_0000_0001, '0);

    // Restart: address changes after two BUSY cycles
    ramREN  = 1'b1;
    ramaddr = 32'h8;
    tick();
    tick();
    checkOutput("restart busy2", DW'(ramstate), DW'(S_BUSY));
    ramaddr = 32'h18;
    for (int i = 0; i < LAT; i++) begin
      tick();
      checkOutput("restart busy", DW'(ramstate), DW'(S_BUSY));
    end
    tick();
    checkOutput("restart access", DW'(ramstate), DW'(S_ACCESS));
    lastLoad = 64'h3333;
    checkOutput("restart load", ramload, lastLoad);
    dropReq();
    tick();
    checkOutput("restart free", DW'(ramstate), DW'(S_FREE));

    // Abort a write after two BUSY cycles
    ramWEN   = 1'b1;
    ramaddr  = 32'h20;
    ramstore = 64'h1;
    tick();
    tick();
    checkOutput("abort busy", DW'(ramstate), DW'(S_BUSY));
    dropReq();
    tick();
    checkOutput("abort free", DW'(ramstate), DW'(S_FREE));
    applyStimulus("rd 0x20", 1'b0, 32'h20, '0, 64'h1234);

    // Highest legal word
    applyStimulus("rd top", 1'b0, 32'h1FF8, '0, 64'h7777_0000_0000_0001);

    // Illegal requests
    applyError("both req", 1'b1, 1'b1, 32'h10);
    applyError("misalign", 1'b1, 1'b0, 32'h4);
    applyError("range", 1'b1, 1'b0, 32'(DEPTH * 8));

    // Reset during a write
    ramWEN   = 1'b1;
    ramaddr  = 32'h0;
    ramstore = 64'h55;
    tick();
    tick();
    checkOutput("rst busy", DW'(ramstate), DW'(S_BUSY));
    nRST = 1'b0;
    #1;
    checkOutput("rst state", DW'(ramstate), DW'(S_FREE));
    checkOutput("rst load", ramload, '0);
    dropReq();
    tick();
    nRST = 1'b1;
    lastLoad = '0;
    tick();
    applyStimulus("rd 0x0", 1'b0, 32'h0, '0, 64'hAA);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
